// File: rtl/audio_dac_pkg.sv
// Shared types and constants for the audio DAC serializer.
//   DEFAULT_DATA_WIDTH : default bits per channel
//   CNT_WIDTH          : bit-slot counter width for the default width
//   cnt_width()        : slot counter width for any channel width (counts to DATA_WIDTH+1)
//   sample_t/stereo_t  : one channel sample / a left-right sample pair
//   lrck_state_e       : frame-tracking states of the serializer
package audio_dac_pkg;

    localparam int DEFAULT_DATA_WIDTH = 16;

    function automatic int cnt_width(input int dw);
        return $clog2(dw + 2);
    endfunction

    localparam int CNT_WIDTH = cnt_width(DEFAULT_DATA_WIDTH);

    typedef logic signed [DEFAULT_DATA_WIDTH-1:0] sample_t;

    typedef struct packed {
        sample_t l;
        sample_t r;
    } stereo_t;

    typedef enum logic {
        ST_SYNC = 1'b0,
        ST_RUN  = 1'b1
    } lrck_state_e;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer for an asynchronous level, with edge detection
// against the previous synchronized value.
//   clk   : sampling clock
//   rst   : asynchronous active-high reset
//   din   : asynchronous input
//   level : synchronized level
//   rise  : one-cycle pulse on a synchronized 0->1
//   fall  : one-cycle pulse on a synchronized 1->0
// STAGES must be at least 2.
module sync_edge_det #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev   <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], din};
            prev   <= sync_q[STAGES-1];
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = level & ~prev;
    assign fall  = ~level & prev;

endmodule

// File: rtl/parallel2dac.sv
// Stereo sample serializer for the codec DAC. Accepts a left/right pair through
// a one-deep holding register and shifts it out MSB first, framed by the
// codec-mastered bit and frame clocks (both synchronized, never used as clocks).
//   CLOCK_50      : system clock
//   reset         : asynchronous active-high reset
//   DACDATA_L/R   : sample pair, two's complement
//   DACDATA_VALID : pair offered; transferred when VALID & READY
//   DACDATA_READY : holding register empty
//   DACDATA_REQ   : pulse, holding register consumed into a frame
//   UNDERRUN      : pulse, left boundary with holding register empty
//   AUD_BCLK      : codec bit clock (async)
//   AUD_DACLRCK   : codec frame clock (async), 0 = left, 1 = right
//   AUD_DACDAT    : serial data, updated one cycle after each synced BCLK fall
//
// state   | meaning
// ST_SYNC | no BCLK fall seen since reset; next fall only records LRCK
// ST_RUN  | LRCK history valid; LRCK changes at BCLK falls are boundaries
module parallel2dac
    import audio_dac_pkg::*;
#(
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int SYNC_STAGES = 2,
    parameter int I2S_DELAY   = 1
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] DACDATA_L,
    input  logic [DATA_WIDTH-1:0] DACDATA_R,
    input  logic                  DACDATA_VALID,
    output logic                  DACDATA_READY,
    output logic                  DACDATA_REQ,
    output logic                  UNDERRUN,
    input  logic                  AUD_BCLK,
    input  logic                  AUD_DACLRCK,
    output logic                  AUD_DACDAT
);

    localparam int               CNT_W    = cnt_width(DATA_WIDTH);
    localparam logic [CNT_W-1:0] SLOT_MAX = CNT_W'(DATA_WIDTH + I2S_DELAY);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] l;
        logic [DATA_WIDTH-1:0] r;
    } pair_t;

    logic bclk_lvl, bclk_rise, bclk_fall;
    logic lrck_lvl, lrck_rise, lrck_fall;
    logic unused_edges;

    sync_edge_det #(.STAGES(SYNC_STAGES)) u_bclk_sync (
        .clk   (CLOCK_50),
        .rst   (reset),
        .din   (AUD_BCLK),
        .level (bclk_lvl),
        .rise  (bclk_rise),
        .fall  (bclk_fall)
    );

    sync_edge_det #(.STAGES(SYNC_STAGES)) u_lrck_sync (
        .clk   (CLOCK_50),
        .rst   (reset),
        .din   (AUD_DACLRCK),
        .level (lrck_lvl),
        .rise  (lrck_rise),
        .fall  (lrck_fall)
    );

    // LRCK is judged only at BCLK falls, so its own edge pulses are not needed.
    assign unused_edges = ^{bclk_lvl, bclk_rise, lrck_rise, lrck_fall};

    lrck_state_e state, state_nxt;
    logic        lrck_prev;
    logic        boundary, left_bnd, right_bnd;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) state <= ST_SYNC;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (state == ST_SYNC && bclk_fall) state_nxt = ST_RUN;
    end

    always_comb begin
        boundary  = (state == ST_RUN) && bclk_fall && (lrck_lvl != lrck_prev);
        left_bnd  = boundary && !lrck_lvl;
        right_bnd = boundary && lrck_lvl;
    end

    pair_t                 hold, frame;
    logic                  full;
    logic                  accept;
    logic [DATA_WIDTH-1:0] word, word_nxt, shifted;
    logic [CNT_W-1:0]      slot, slot_nxt;
    logic                  dac_bit;
    int                    slot_i;

    assign accept        = DACDATA_VALID && !full;
    assign DACDATA_READY = !full;
    assign DACDATA_REQ   = left_bnd && full;
    assign UNDERRUN      = left_bnd && !full;

    // A full holding register is bypassed straight into the left word so the
    // new sample starts in the same slot it is consumed; on underrun the frame
    // registers still hold the previous pair, which therefore repeats.
    always_comb begin
        slot_nxt = slot;
        word_nxt = word;
        if (boundary)
            slot_nxt = '0;
        else if (bclk_fall && slot != SLOT_MAX)
            slot_nxt = slot + CNT_W'(1);
        if (left_bnd)
            word_nxt = full ? hold.l : frame.l;
        else if (right_bnd)
            word_nxt = frame.r;
    end

    // Data occupies slots I2S_DELAY .. I2S_DELAY+DATA_WIDTH-1, MSB first.
    always_comb begin
        slot_i  = int'(slot_nxt);
        shifted = word_nxt << (slot_i - I2S_DELAY);
        dac_bit = (slot_i >= I2S_DELAY) && (slot_i < I2S_DELAY + DATA_WIDTH)
                  && shifted[DATA_WIDTH-1];
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            hold       <= '0;
            frame      <= '0;
            full       <= 1'b0;
            word       <= '0;
            slot       <= '0;
            lrck_prev  <= 1'b0;
            AUD_DACDAT <= 1'b0;
        end else begin
            if (accept) begin
                hold.l <= DACDATA_L;
                hold.r <= DACDATA_R;
                full   <= 1'b1;
            end else if (DACDATA_REQ) begin
                full   <= 1'b0;
            end
            if (DACDATA_REQ) frame <= hold;
            if (bclk_fall) begin
                lrck_prev  <= lrck_lvl;
                AUD_DACDAT <= dac_bit;
            end
            slot <= slot_nxt;
            word <= word_nxt;
        end
    end

endmodule

// File: tb/tb_parallel2dac.sv
`timescale 1ns/1ps
module tb_parallel2dac;

    logic        clk_50 = 1'b0;
    logic        reset;
    logic [15:0] data_l, data_r;
    logic        valid;
    logic        ready, req, underrun, dacdat;
    logic        ready0, req0, underrun0, dacdat0;
    logic        bclk, lrck;

    always #10 clk_50 = ~clk_50;

    parallel2dac #(.DATA_WIDTH(16), .SYNC_STAGES(2), .I2S_DELAY(1)) dut (
        .CLOCK_50      (clk_50),
        .reset         (reset),
        .DACDATA_L     (data_l),
        .DACDATA_R     (data_r),
        .DACDATA_VALID (valid),
        .DACDATA_READY (ready),
        .DACDATA_REQ   (req),
        .UNDERRUN      (underrun),
        .AUD_BCLK      (bclk),
        .AUD_DACLRCK   (lrck),
        .AUD_DACDAT    (dacdat)
    );

    parallel2dac #(.DATA_WIDTH(16), .SYNC_STAGES(2), .I2S_DELAY(0)) dut0 (
        .CLOCK_50      (clk_50),
        .reset         (reset),
        .DACDATA_L     (data_l),
        .DACDATA_R     (data_r),
        .DACDATA_VALID (valid),
        .DACDATA_READY (ready0),
        .DACDATA_REQ   (req0),
        .UNDERRUN      (underrun0),
        .AUD_BCLK      (bclk),
        .AUD_DACLRCK   (lrck),
        .AUD_DACDAT    (dacdat0)
    );

    // Codec model: BCLK period 16 cycles, 32 slots per LRCK half, starts at left
    // slot 0. It samples DACDAT on each BCLK rise and pushes every completed
    // channel (32 slots, first slot in bit 31) into rx_q / rx0_q.
    logic        codec_run = 1'b0;
    int          cur_slot;
    logic        cur_chan;
    logic [31:0] rx_q[$];
    logic [31:0] rx0_q[$];

    initial begin : codec
        int          tick;
        logic [31:0] v, v0;
        bclk = 1'b1; lrck = 1'b1; tick = 0; cur_slot = 0; cur_chan = 1'b0;
        v = '0; v0 = '0;
        forever begin
            @(posedge clk_50); #1;
            if (!codec_run) begin
                bclk = 1'b1; tick = 0; cur_slot = 0; cur_chan = 1'b0;
                v = '0; v0 = '0;
            end else begin
                if (tick == 0) begin
                    bclk = 1'b0;
                    if (cur_slot == 0) lrck = cur_chan;
                end else if (tick == 8) begin
                    bclk = 1'b1;
                    v  = {v[30:0], dacdat};
                    v0 = {v0[30:0], dacdat0};
                    if (cur_slot == 31) begin
                        rx_q.push_back(v);
                        rx0_q.push_back(v0);
                    end
                end
                tick++;
                if (tick == 16) begin
                    tick = 0;
                    cur_slot++;
                    if (cur_slot == 32) begin
                        cur_slot = 0;
                        cur_chan = ~cur_chan;
                    end
                end
            end
        end
    end

    int req_cnt = 0;
    int und_cnt = 0;
    always @(negedge clk_50) begin
        if (req)      req_cnt <= req_cnt + 1;
        if (underrun) und_cnt <= und_cnt + 1;
    end

    int errors = 0;
    int checks = 0;

    // Expected channel as seen by the codec: `delay` zero slots, the sample
    // MSB first, then zeros to the end of the 32-slot half.
    function automatic logic [31:0] exp_vec(input logic [15:0] s, input int delay);
        logic [31:0] v;
        v = {s, 16'h0000};
        return v >> delay;
    endfunction

    task automatic do_reset();
        codec_run = 1'b0;
        valid     = 1'b0;
        reset     = 1'b1;
        repeat (4) @(posedge clk_50);
        #1 reset = 1'b0;
        repeat (6) @(posedge clk_50);
        #1;
    endtask

    task automatic send(input logic [15:0] l, input logic [15:0] r);
        bit ok;
        int guard;
        ok = 0; guard = 0;
        data_l = l; data_r = r; valid = 1'b1;
        while (!ok && guard < 5000) begin
            @(negedge clk_50);
            if (ready) ok = 1;
            @(posedge clk_50); #1;
            guard++;
        end
        valid = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL send_accept: READY never seen, wanted accept of %h/%h", l, r);
        end
    endtask

    task automatic wait_chans(input int target);
        int guard;
        guard = 0;
        while (rx_q.size() < target && guard < 20000) begin
            @(posedge clk_50);
            guard++;
        end
        #1;
        checks++;
        if (rx_q.size() < target) begin
            errors++;
            $display("FAIL wait_chans: got %0d channels, wanted %0d", rx_q.size(), target);
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $fatal(1, "codec capture timed out");
        end
    endtask

    task automatic test_reset();
        int r0, u0, guard;
        codec_run = 1'b0;
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk_50); #1;
            valid  = 1'($urandom);
            data_l = 16'($urandom);
            data_r = 16'($urandom);
        end
        @(negedge clk_50);
        checks++;
        if (dacdat !== 1'b0) begin errors++; $display("FAIL reset_dacdat: got %b expected 0", dacdat); end
        checks++;
        if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", ready); end
        checks++;
        if (req !== 1'b0 || underrun !== 1'b0) begin
            errors++; $display("FAIL reset_pulses: got req=%b und=%b expected 0/0", req, underrun);
        end
        checks++;
        if ({dacdat0, ready0, req0, underrun0} !== 4'b0100) begin
            errors++; $display("FAIL reset_dut0: got %b expected 0100", {dacdat0, ready0, req0, underrun0});
        end
        @(posedge clk_50); #1;
        valid = 1'b0;
        reset = 1'b0;
        repeat (6) @(posedge clk_50);
        #1;
        r0 = req_cnt; u0 = und_cnt;
        codec_run = 1'b1;
        guard = 0;
        while (cur_slot < 2 && guard < 200) begin @(posedge clk_50); guard++; end
        @(negedge clk_50);
        checks++;
        if (req_cnt != r0 || und_cnt != u0) begin
            errors++;
            $display("FAIL first_edge: got req+%0d und+%0d expected +0/+0", req_cnt - r0, und_cnt - u0);
        end
        codec_run = 1'b0;
    endtask

    int nom_base, nom_req, nom_und;

    task automatic test_nominal();
        do_reset();
        nom_base = rx_q.size();
        nom_req = req_cnt; nom_und = und_cnt;
        send(16'hA5C3, 16'h0F0F);
        codec_run = 1'b1;
        wait_chans(nom_base + 4);
        checks++;
        if (rx_q[nom_base] !== 32'h0) begin
            errors++; $display("FAIL nominal_l0_silent: got %h expected 00000000", rx_q[nom_base]);
        end
        checks++;
        if (rx_q[nom_base+2] !== 32'h52E1_8000) begin
            errors++; $display("FAIL nominal_left: got %h expected 52e18000", rx_q[nom_base+2]);
        end
        checks++;
        if (rx_q[nom_base+3] !== 32'h0787_8000) begin
            errors++; $display("FAIL nominal_right: got %h expected 07878000", rx_q[nom_base+3]);
        end
        checks++;
        if (req_cnt - nom_req != 1 || und_cnt - nom_und != 0) begin
            errors++;
            $display("FAIL nominal_pulses: got req=%0d und=%0d expected 1/0", req_cnt - nom_req, und_cnt - nom_und);
        end
    endtask

    task automatic test_underrun();
        int r0, u0;
        r0 = req_cnt; u0 = und_cnt;
        wait_chans(nom_base + 6);
        checks++;
        if (rx_q[nom_base+4] !== 32'h52E1_8000) begin
            errors++; $display("FAIL underrun_left_repeat: got %h expected 52e18000", rx_q[nom_base+4]);
        end
        checks++;
        if (rx_q[nom_base+5] !== 32'h0787_8000) begin
            errors++; $display("FAIL underrun_right_repeat: got %h expected 07878000", rx_q[nom_base+5]);
        end
        checks++;
        if (und_cnt - u0 != 1 || req_cnt - r0 != 0) begin
            errors++;
            $display("FAIL underrun_pulses: got und=%0d req=%0d expected 1/0", und_cnt - u0, req_cnt - r0);
        end
        codec_run = 1'b0;
    endtask

    task automatic test_back_pressure();
        int base, r0, u0, ready_early, guard;
        bit seen_req;
        logic [15:0] r1, r2;
        r1 = 16'($urandom); r2 = 16'($urandom);
        do_reset();
        base = rx_q.size();
        r0 = req_cnt; u0 = und_cnt;
        send(16'h1111, r1);
        codec_run = 1'b1;
        data_l = 16'h2222; data_r = r2; valid = 1'b1;
        ready_early = 0; seen_req = 0; guard = 0;
        while (!seen_req && guard < 4000) begin
            @(negedge clk_50);
            guard++;
            if (ready) ready_early++;
            if (req) seen_req = 1;
        end
        checks++;
        if (!seen_req || ready_early != 0) begin
            errors++;
            $display("FAIL bp_ready_low: got req_seen=%0d ready_cycles=%0d expected 1/0", seen_req, ready_early);
        end
        @(negedge clk_50);
        checks++;
        if (ready !== 1'b1) begin errors++; $display("FAIL bp_ready_after_req: got %b expected 1", ready); end
        @(posedge clk_50); #1;
        valid = 1'b0;
        @(negedge clk_50);
        checks++;
        if (ready !== 1'b0) begin errors++; $display("FAIL bp_refilled: got ready=%b expected 0", ready); end
        wait_chans(base + 6);
        checks++;
        if (rx_q[base+2] !== exp_vec(16'h1111, 1) || rx_q[base+3] !== exp_vec(r1, 1)) begin
            errors++;
            $display("FAIL bp_frame1: got %h/%h expected %h/%h", rx_q[base+2], rx_q[base+3],
                     exp_vec(16'h1111, 1), exp_vec(r1, 1));
        end
        checks++;
        if (rx_q[base+4] !== exp_vec(16'h2222, 1) || rx_q[base+5] !== exp_vec(r2, 1)) begin
            errors++;
            $display("FAIL bp_frame2: got %h/%h expected %h/%h", rx_q[base+4], rx_q[base+5],
                     exp_vec(16'h2222, 1), exp_vec(r2, 1));
        end
        checks++;
        if (req_cnt - r0 != 2 || und_cnt - u0 != 0) begin
            errors++;
            $display("FAIL bp_pulses: got req=%0d und=%0d expected 2/0", req_cnt - r0, und_cnt - u0);
        end
        codec_run = 1'b0;
    endtask

    task automatic test_left_justified();
        int base;
        logic [15:0] r;
        r = 16'($urandom);
        do_reset();
        base = rx_q.size();
        send(16'h8001, r);
        codec_run = 1'b1;
        wait_chans(base + 4);
        checks++;
        if (rx0_q[base+2] !== 32'h8001_0000) begin
            errors++; $display("FAIL lj_left: got %h expected 80010000", rx0_q[base+2]);
        end
        checks++;
        if (rx0_q[base+3] !== exp_vec(r, 0)) begin
            errors++; $display("FAIL lj_right: got %h expected %h", rx0_q[base+3], exp_vec(r, 0));
        end
        codec_run = 1'b0;
    endtask

    task automatic test_random_stream();
        localparam int N = 4;
        logic [15:0] pl[N], pr[N];
        logic [15:0] el, er;
        int base, r0, u0;
        for (int i = 0; i < N; i++) begin
            pl[i] = 16'($urandom);
            pr[i] = 16'($urandom);
        end
        do_reset();
        base = rx_q.size();
        r0 = req_cnt; u0 = und_cnt;
        send(pl[0], pr[0]);
        codec_run = 1'b1;
        for (int i = 1; i < N; i++) send(pl[i], pr[i]);
        wait_chans(base + 2 * (N + 2));
        // Frame k plays pair k-1; the frame after the last pair repeats it.
        for (int k = 1; k <= N + 1; k++) begin
            el = (k <= N) ? pl[k-1] : pl[N-1];
            er = (k <= N) ? pr[k-1] : pr[N-1];
            checks++;
            if (rx_q[base+2*k] !== exp_vec(el, 1) || rx_q[base+2*k+1] !== exp_vec(er, 1)) begin
                errors++;
                $display("FAIL stream_i2s frame %0d: got %h/%h expected %h/%h", k,
                         rx_q[base+2*k], rx_q[base+2*k+1], exp_vec(el, 1), exp_vec(er, 1));
            end
            checks++;
            if (rx0_q[base+2*k] !== exp_vec(el, 0) || rx0_q[base+2*k+1] !== exp_vec(er, 0)) begin
                errors++;
                $display("FAIL stream_lj frame %0d: got %h/%h expected %h/%h", k,
                         rx0_q[base+2*k], rx0_q[base+2*k+1], exp_vec(el, 0), exp_vec(er, 0));
            end
        end
        checks++;
        if (req_cnt - r0 != N || und_cnt - u0 != 1) begin
            errors++;
            $display("FAIL stream_pulses: got req=%0d und=%0d expected %0d/1", req_cnt - r0, und_cnt - u0, N);
        end
        codec_run = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        int base, guard;
        logic [15:0] cl, cr;
        cl = 16'($urandom); cr = 16'($urandom);
        do_reset();
        base = rx_q.size();
        send(16'hFFFF, 16'($urandom));
        codec_run = 1'b1;
        wait_chans(base + 2);
        send(16'($urandom), 16'($urandom));
        guard = 0;
        while (cur_slot != 7 && guard < 2000) begin @(posedge clk_50); guard++; end
        repeat (6) @(posedge clk_50);
        @(negedge clk_50);
        checks++;
        if (dacdat !== 1'b1 || ready !== 1'b0) begin
            errors++; $display("FAIL mid_pre_reset: got dacdat=%b ready=%b expected 1/0", dacdat, ready);
        end
        @(posedge clk_50); #1;
        reset = 1'b1;
        @(negedge clk_50);
        checks++;
        if (dacdat !== 1'b0 || ready !== 1'b1) begin
            errors++; $display("FAIL mid_reset: got dacdat=%b ready=%b expected 0/1", dacdat, ready);
        end
        codec_run = 1'b0;
        repeat (4) @(posedge clk_50);
        #1 reset = 1'b0;
        repeat (6) @(posedge clk_50);
        #1;
        base = rx_q.size();
        send(cl, cr);
        codec_run = 1'b1;
        wait_chans(base + 4);
        checks++;
        if (rx_q[base] !== 32'h0) begin
            errors++; $display("FAIL mid_after_l0: got %h expected 00000000", rx_q[base]);
        end
        checks++;
        if (rx_q[base+2] !== exp_vec(cl, 1) || rx_q[base+3] !== exp_vec(cr, 1)) begin
            errors++;
            $display("FAIL mid_after_frame: got %h/%h expected %h/%h", rx_q[base+2], rx_q[base+3],
                     exp_vec(cl, 1), exp_vec(cr, 1));
        end
        codec_run = 1'b0;
    endtask

    initial begin
        reset  = 1'b1;
        valid  = 1'b0;
        data_l = '0;
        data_r = '0;
        test_reset();
        test_nominal();
        test_underrun();
        test_back_pressure();
        test_left_justified();
        test_random_stream();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
